dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (dmem) between two requesters:
  - m0: the CPU load/store path.
  - m1: the debug/host loader port.
- Sits between the requesters and the dmem instance; owns all dmem read/write enables and address/data muxing.
- Uses burst-aware round-robin arbitration with a bounded hold, so neither side can starve the other.
- Tracks outstanding reads and returns each read response to the master that issued it.

Parameters:
- DATAWIDTH, 32, data word width.
- ADDRWIDTH, 32, byte address width.
- RD_LATENCY, 1, cycles from an issued read to valid mem_rdata_i; legal range 1..4.
- MAX_BURST, 4, maximum consecutive grants to one master while the other is requesting; legal range 1..15.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-low reset.
- m0_req_i  in  1  CPU requests an access this cycle.
- m0_we_i  in  1  1 = write, 0 = read.
- m0_addr_i  in  ADDRWIDTH  CPU address.
- m0_wdata_i  in  DATAWIDTH  CPU write data.
- m0_gnt_o  out  1  CPU access accepted this cycle.
- m0_rvalid_o  out  1  CPU read data valid.
- m0_rdata_o  out  DATAWIDTH  CPU read data.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: same as the m0 ports, for the host.
- mem_re_o  out  1  dmem read enable.
- mem_we_o  out  1  dmem write enable.
- mem_addr_o  out  ADDRWIDTH  dmem address; drives both the read and write address.
- mem_wdata_o  out  DATAWIDTH  dmem write data.
- mem_rdata_i  in  DATAWIDTH  dmem read data.
- busy_o  out  1  at least one read outstanding.

Behaviour:
- Reset (rst_i = 0 at a clock edge):
  - State goes to IDLE; last-owner goes to m1 (so m0 wins first); burst counter = 0; tag pipeline cleared.
  - All grant, rvalid, mem_re and mem_we outputs are 0. rdata and addr outputs are 0.
  - Reads outstanding at reset are dropped: no rvalid may appear after reset deasserts.
- Grant is combinational from the req inputs and the registered state:
  - At most one gnt is high per cycle.
  - A transaction is accepted when req and gnt are both high in the same cycle.
  - The requester must hold req, we, addr and wdata stable until it is granted.
- Memory issue:
  - The granted master's addr and wdata are muxed to the mem outputs.
  - mem_we_o = granted & we; mem_re_o = granted & ~we.
  - With no grant, mem_re_o and mem_we_o are 0; addr and wdata hold their last values.
- State machine states: IDLE, OWN0, OWN1.
  - IDLE: only m0 requests -> grant m0, go to OWN0. Only m1 -> grant m1, go to OWN1. Both -> grant the master that is not the last owner.
  - OWNx, x requesting, other idle -> keep granting x; counter saturates.
  - OWNx, both requesting, counter < MAX_BURST -> grant x, counter+1.
  - OWNx, both requesting, counter = MAX_BURST -> grant the other master, switch state, counter = 1.
  - OWNx, x idle, other requesting -> grant the other master immediately (no bubble), switch state, counter = 1.
  - No requests -> go to IDLE, counter = 0. The last-owner register keeps the previous owner.
- Read return:
  - Each accepted read pushes {valid, id} into an RD_LATENCY-deep shift register.
  - When the entry exits the shift register, the matching mN_rvalid_o pulses for 1 cycle, with mN_rdata_o = mem_rdata_i.
  - The other master's rvalid is 0 and its rdata holds its last value.
  - Writes produce no response.
- Fixed timing: a read accepted in cycle t returns in cycle t + RD_LATENCY.
  - Back-to-back reads give back-to-back responses, in issue order.
- busy_o is the OR of the valid bits in the tag pipeline.
- Simultaneous events: a new grant and a read return in the same cycle are independent; both occur.
- An m0 write followed next cycle by an m1 read of the same address returns the written data; ordering follows dmem write-first semantics.

Optional Feature:
- Macro ARB_M0_PRIORITY_EN.
- Defined: the CPU (m0) always wins when both request, except after MAX_BURST consecutive m0 grants with m1 waiting. Then m1 gets exactly 1 grant and the counter resets. The OWN1 burst hold is disabled.
- Undefined: fair round-robin with bounded hold, as described in Behaviour.

Test Plan:
- Reset with m0_req_i = 1: all gnt, rvalid, mem_re and mem_we are 0 during reset. The first cycle after reset: m0_gnt_o = 1, mem_addr_o = m0_addr_i.
- m0 read of 0x10 with dmem[0x10] = 0xDEADBEEF, RD_LATENCY = 1 -> m0_rvalid_o = 1 and m0_rdata_o = 0xDEADBEEF one cycle later; m1_rvalid_o = 0.
- Both masters request continuously with MAX_BURST = 4 -> grant sequence m0 ×4, m1 ×4, m0 ×4, with no idle cycles.
- m0 requests 1 cycle, then only m1 requests -> m1 granted the very next cycle; counter = 1.
- RD_LATENCY = 3, alternating m0/m1 reads of 0x0, 0x4, 0x8 -> rvalid pulses alternate m0/m1 in issue order at t+3.
- Read accepted, then reset asserted 1 cycle later -> no rvalid on either port afterwards; busy_o = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: burst-limited round-robin grant,
// address/data muxing and read-tag tracking. Define ARB_M0_PRIORITY_EN for m0-priority arbitration.
module dmem_arbiter #(
  parameter int DATAWIDTH  = 32,
  parameter int ADDRWIDTH  = 32,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 m0_req_i,
  input  logic                 m0_we_i,
  input  logic [ADDRWIDTH-1:0] m0_addr_i,
  input  logic [DATAWIDTH-1:0] m0_wdata_i,
  output logic                 m0_gnt_o,
  output logic                 m0_rvalid_o,
  output logic [DATAWIDTH-1:0] m0_rdata_o,
  input  logic                 m1_req_i,
  input  logic                 m1_we_i,
  input  logic [ADDRWIDTH-1:0] m1_addr_i,
  input  logic [DATAWIDTH-1:0] m1_wdata_i,
  output logic                 m1_gnt_o,
  output logic                 m1_rvalid_o,
  output logic [DATAWIDTH-1:0] m1_rdata_o,
  output logic                 mem_re_o,
  output logic                 mem_we_o,
  output logic [ADDRWIDTH-1:0] mem_addr_o,
  output logic [DATAWIDTH-1:0] mem_wdata_o,
  input  logic [DATAWIDTH-1:0] mem_rdata_i,
  output logic                 busy_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  state_t         state_reg, state_next;
  logic           last_owner_reg, last_owner_next;  // 1 = m1 owned the most recent grant
  logic [3:0]     burst_cnt_reg, burst_cnt_next;
  logic [3:0]     cnt_inc;
  logic           raw_gnt0, raw_gnt1;

  logic [ADDRWIDTH-1:0] addr_hold_reg;
  logic [DATAWIDTH-1:0] wdata_hold_reg;
  logic [DATAWIDTH-1:0] rdata0_hold_reg, rdata1_hold_reg;
  logic [RD_LATENCY-1:0] tag_valid_reg, tag_valid_next;
  logic [RD_LATENCY-1:0] tag_id_reg, tag_id_next;

  logic                 gnt_any;
  logic                 sel_we;
  logic [ADDRWIDTH-1:0] sel_addr;
  logic [DATAWIDTH-1:0] sel_wdata;
  logic                 rsp_valid;

  assign cnt_inc = (burst_cnt_reg >= MAX_CNT) ? burst_cnt_reg : burst_cnt_reg + 4'd1;

  always_comb begin
    raw_gnt0        = 1'b0;
    raw_gnt1        = 1'b0;
    state_next      = IDLE;
    burst_cnt_next  = 4'd0;
    last_owner_next = last_owner_reg;
`ifdef ARB_M0_PRIORITY_EN
    // m0 wins ties; m1 only breaks in once m0 has used up its burst allowance.
    if (m0_req_i && m1_req_i) begin
      if (state_reg == OWN0 && burst_cnt_reg >= MAX_CNT) raw_gnt1 = 1'b1;
      else                                               raw_gnt0 = 1'b1;
    end else begin
      raw_gnt0 = m0_req_i;
      raw_gnt1 = m1_req_i;
    end
`else
    case (state_reg)
      OWN0: begin
        if (m0_req_i && (!m1_req_i || burst_cnt_reg < MAX_CNT)) raw_gnt0 = 1'b1;
        else if (m1_req_i)                                      raw_gnt1 = 1'b1;
      end
      OWN1: begin
        if (m1_req_i && (!m0_req_i || burst_cnt_reg < MAX_CNT)) raw_gnt1 = 1'b1;
        else if (m0_req_i)                                      raw_gnt0 = 1'b1;
      end
      default: begin
        if (m0_req_i && m1_req_i) begin
          raw_gnt0 = last_owner_reg;
          raw_gnt1 = ~last_owner_reg;
        end else begin
          raw_gnt0 = m0_req_i;
          raw_gnt1 = m1_req_i;
        end
      end
    endcase
`endif
    if (raw_gnt0) begin
      state_next      = OWN0;
      last_owner_next = 1'b0;
      burst_cnt_next  = (state_reg == OWN0) ? cnt_inc : 4'd1;
    end else if (raw_gnt1) begin
      state_next      = OWN1;
      last_owner_next = 1'b1;
`ifdef ARB_M0_PRIORITY_EN
      burst_cnt_next  = 4'd0;
`else
      burst_cnt_next  = (state_reg == OWN1) ? cnt_inc : 4'd1;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      last_owner_reg <= 1'b1;
      burst_cnt_reg  <= 4'd0;
      tag_valid_reg  <= '0;
      tag_id_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      burst_cnt_reg  <= burst_cnt_next;
      tag_valid_reg  <= tag_valid_next;
      tag_id_reg     <= tag_id_next;
    end
  end

  // Grants are suppressed while reset is held so nothing issues to dmem.
  assign m0_gnt_o  = raw_gnt0 & rst_i;
  assign m1_gnt_o  = raw_gnt1 & rst_i;
  assign gnt_any   = m0_gnt_o | m1_gnt_o;
  assign sel_we    = m1_gnt_o ? m1_we_i    : m0_we_i;
  assign sel_addr  = m1_gnt_o ? m1_addr_i  : m0_addr_i;
  assign sel_wdata = m1_gnt_o ? m1_wdata_i : m0_wdata_i;

  assign mem_we_o    = gnt_any & sel_we;
  assign mem_re_o    = gnt_any & ~sel_we;
  assign mem_addr_o  = gnt_any ? sel_addr  : addr_hold_reg;
  assign mem_wdata_o = gnt_any ? sel_wdata : wdata_hold_reg;

  genvar gi;
  generate
    for (gi = 0; gi < RD_LATENCY; gi++) begin : g_tag
      if (gi == 0) begin : g_head
        assign tag_valid_next[gi] = mem_re_o;
        assign tag_id_next[gi]    = m1_gnt_o;
      end else begin : g_shift
        assign tag_valid_next[gi] = tag_valid_reg[gi-1];
        assign tag_id_next[gi]    = tag_id_reg[gi-1];
      end
    end
  endgenerate

  // A tag leaving the pipeline while reset is low belongs to a dropped read.
  assign rsp_valid   = tag_valid_reg[RD_LATENCY-1] & rst_i;
  assign m0_rvalid_o = rsp_valid & ~tag_id_reg[RD_LATENCY-1];
  assign m1_rvalid_o = rsp_valid &  tag_id_reg[RD_LATENCY-1];
  assign m0_rdata_o  = m0_rvalid_o ? mem_rdata_i : rdata0_hold_reg;
  assign m1_rdata_o  = m1_rvalid_o ? mem_rdata_i : rdata1_hold_reg;
  assign busy_o      = |tag_valid_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      addr_hold_reg   <= '0;
      wdata_hold_reg  <= '0;
      rdata0_hold_reg <= '0;
      rdata1_hold_reg <= '0;
    end else begin
      if (gnt_any) begin
        addr_hold_reg  <= sel_addr;
        wdata_hold_reg <= sel_wdata;
      end
      if (m0_rvalid_o) rdata0_hold_reg <= mem_rdata_i;
      if (m1_rvalid_o) rdata1_hold_reg <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 3) share stimulus and are
// checked every cycle against a transaction-level model, plus hand-computed spot values.
module tb_dmem_arbiter;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        a_m0_gnt, a_m1_gnt, a_m0_rv, a_m1_rv, a_re, a_we, a_busy;
  logic [31:0] a_m0_rd, a_m1_rd, a_addr, a_wdata, a_mem_rdata;
  logic        b_m0_gnt, b_m1_gnt, b_m0_rv, b_m1_rv, b_re, b_we, b_busy;
  logic [31:0] b_m0_rd, b_m1_rd, b_addr, b_wdata, b_mem_rdata;

  dmem_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(32), .RD_LATENCY(1), .MAX_BURST(MAXB)) dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rv), .m0_rdata_o(a_m0_rd),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rv), .m1_rdata_o(a_m1_rd),
    .mem_re_o(a_re), .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_wdata_o(a_wdata),
    .mem_rdata_i(a_mem_rdata), .busy_o(a_busy));

  dmem_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(32), .RD_LATENCY(3), .MAX_BURST(MAXB)) dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rv), .m0_rdata_o(b_m0_rd),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rv), .m1_rdata_o(b_m1_rd),
    .mem_re_o(b_re), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
    .mem_rdata_i(b_mem_rdata), .busy_o(b_busy));

  // ---------------- dmem model (environment): 64 words, unwritten words have a fixed pattern
  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
  endfunction

  logic [31:0] wr_data [64];
  logic [63:0] wr_mask = '0;
  logic [31:0] b_pipe [3];

  function automatic logic [31:0] mem_rd(logic [31:0] addr);
    return wr_mask[addr[7:2]] ? wr_data[addr[7:2]] : init_word(int'(addr[7:2]));
  endfunction

  always @(posedge clk) begin
    if (a_we) begin
      wr_data[a_addr[7:2]] <= a_wdata;
      wr_mask[a_addr[7:2]] <= 1'b1;
    end
    a_mem_rdata <= mem_rd(a_addr);
    b_pipe[0]   <= mem_rd(b_addr);
    b_pipe[1]   <= b_pipe[0];
    b_pipe[2]   <= b_pipe[1];
  end
  assign b_mem_rdata = b_pipe[2];

  // ---------------- transaction-level reference model
  typedef struct {
    int          due;
    bit          id;
    logic [31:0] data;
  } rsp_t;

  rsp_t        rq0[$];
  rsp_t        rq1[$];
  logic [31:0] sh_data [64];
  logic [63:0] sh_mask;
  logic [31:0] rd_last [2][2];
  logic [31:0] addr_last, wdata_last;
  int          cyc, run, errs, checks;
  bit          known, have_own, own, last;

  // snapshots taken at the sampling edge of the latest tick
  logic        sa_m0_gnt, sa_m1_gnt, sa_m0_rv, sa_m1_rv, sa_busy, sb_m0_rv, sb_m1_rv, sb_busy;
  logic [31:0] sa_addr, sa_m0_rd, sa_m1_rd, sb_m0_rd, sb_m1_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sh_rd(logic [31:0] addr);
    return sh_mask[addr[7:2]] ? sh_data[addr[7:2]] : init_word(int'(addr[7:2]));
  endfunction

  task automatic chk_rsp(input int k, input logic rv0, input logic rv1,
                         input logic [31:0] rd0, input logic [31:0] rd1, input logic busy);
    rsp_t  h;
    bit    has;
    int    n;
    string tag;
    tag = (k == 0) ? "a" : "b";
    has = 1'b0;
    h   = '{due: 0, id: 1'b0, data: 32'h0};
    if (k == 0) begin
      n = rq0.size();
      if (n > 0 && rq0[0].due == cyc) begin has = 1'b1; h = rq0[0]; end
    end else begin
      n = rq1.size();
      if (n > 0 && rq1[0].due == cyc) begin has = 1'b1; h = rq1[0]; end
    end
    chk({"busy_", tag}, 32'(busy), 32'(n != 0));
    chk({"rvalid_", tag}, 32'({rv0, rv1}), 32'({has && !h.id, has && h.id}));
    if (has) rd_last[k][h.id] = h.data;
    chk({"m0_rdata_", tag}, rd0, rd_last[k][0]);
    chk({"m1_rdata_", tag}, rd1, rd_last[k][1]);
    if (has) begin
      if (k == 0) void'(rq0.pop_front());
      else        void'(rq1.pop_front());
    end
  endtask

  // One clock cycle: sample at the falling edge, compare against the model, advance the model.
  task automatic tick();
    bit          grant, w, w_we;
    logic [31:0] w_addr, w_wdata, e_addr, e_wdata;
    @(negedge clk);
    sa_m0_gnt = a_m0_gnt; sa_m1_gnt = a_m1_gnt; sa_addr = a_addr; sa_busy = a_busy;
    sa_m0_rv  = a_m0_rv;  sa_m1_rv  = a_m1_rv;  sa_m0_rd = a_m0_rd; sa_m1_rd = a_m1_rd;
    sb_m0_rv  = b_m0_rv;  sb_m1_rv  = b_m1_rv;  sb_m0_rd = b_m0_rd; sb_m1_rd = b_m1_rd;
    sb_busy   = b_busy;
    if (!rst_n) begin
      chk("rst_out_a", 32'({a_m0_gnt, a_m1_gnt, a_re, a_we, a_m0_rv, a_m1_rv}), 32'h0);
      chk("rst_out_b", 32'({b_m0_gnt, b_m1_gnt, b_re, b_we, b_m0_rv, b_m1_rv}), 32'h0);
      rq0.delete();
      rq1.delete();
      for (int k = 0; k < 2; k++) for (int j = 0; j < 2; j++) rd_last[k][j] = 32'h0;
      addr_last = 32'h0; wdata_last = 32'h0;
      have_own = 1'b0; run = 0; last = 1'b1; known = 1'b1;
    end else if (known) begin
      grant = m0_req | m1_req;
      if (m0_req && m1_req) begin
        if (!have_own)       w = ~last;
        else if (run < MAXB) w = own;
        else                 w = ~own;
      end else begin
        w = m1_req;
      end
      w_we    = w ? m1_we    : m0_we;
      w_addr  = w ? m1_addr  : m0_addr;
      w_wdata = w ? m1_wdata : m0_wdata;
      e_addr  = grant ? w_addr  : addr_last;
      e_wdata = grant ? w_wdata : wdata_last;
      chk("gnt_a", 32'({a_m0_gnt, a_m1_gnt}), 32'({grant && !w, grant && w}));
      chk("gnt_b", 32'({b_m0_gnt, b_m1_gnt}), 32'({grant && !w, grant && w}));
      chk("mem_en_a", 32'({a_re, a_we}), 32'({grant && !w_we, grant && w_we}));
      chk("mem_en_b", 32'({b_re, b_we}), 32'({grant && !w_we, grant && w_we}));
      chk("mem_addr_a", a_addr, e_addr);
      chk("mem_addr_b", b_addr, e_addr);
      chk("mem_wdata_a", a_wdata, e_wdata);
      chk("mem_wdata_b", b_wdata, e_wdata);
      chk_rsp(0, a_m0_rv, a_m1_rv, a_m0_rd, a_m1_rd, a_busy);
      chk_rsp(1, b_m0_rv, b_m1_rv, b_m0_rd, b_m1_rd, b_busy);
      if (grant) begin
        addr_last  = w_addr;
        wdata_last = w_wdata;
        if (w_we) begin
          sh_data[w_addr[7:2]] = w_wdata;
          sh_mask[w_addr[7:2]] = 1'b1;
          $display("cyc %0d: m%0d WR addr=%h data=%h", cyc, w, w_addr, w_wdata);
        end else begin
          rq0.push_back('{due: cyc + 1, id: w, data: sh_rd(w_addr)});
          rq1.push_back('{due: cyc + 3, id: w, data: sh_rd(w_addr)});
          $display("cyc %0d: m%0d RD addr=%h data=%h", cyc, w, w_addr, sh_rd(w_addr));
        end
        run      = (have_own && own == w) ? run + 1 : 1;
        own      = w;
        have_own = 1'b1;
        last     = w;
      end else begin
        have_own = 1'b0;
        run      = 0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    repeat (n) tick();
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0; known = 1'b0; sh_mask = '0;
    have_own = 1'b0; own = 1'b0; last = 1'b1; run = 0;
    rst_n = 1'b0;
    drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);

    // reset held with m0 requesting
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("first_gnt_m0", 32'(sa_m0_gnt), 32'h1);
    chk("first_addr", sa_addr, 32'h10);
    idle(1);
    chk("rd1_m0_rvalid", 32'(sa_m0_rv), 32'h1);
    chk("rd1_m0_rdata", sa_m0_rd, 32'hDEADBEEF);
    chk("rd1_m1_rvalid", 32'(sa_m1_rv), 32'h0);
    idle(2);
    chk("rd3_m0_rvalid", 32'(sb_m0_rv), 32'h1);
    chk("rd3_m0_rdata", sb_m0_rd, 32'hDEADBEEF);

    // m0 write then m1 read of the same word
    drive(1, 1, 32'h40, 32'h12345678, 0, 0, 32'h0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    tick();
    chk("wr_rd_m1_gnt", 32'(sa_m1_gnt), 32'h1);
    idle(1);
    chk("wr_rd_m1_rdata", sa_m1_rd, 32'h12345678);
    idle(3);

    // both requesting continuously: m0 x4, m1 x4, m0 x4
    drive(1, 0, 32'h20, 32'h0, 1, 1, 32'h30, 32'hA0A00001);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("burst_m1_gnt", 32'(sa_m1_gnt), 32'(((i / MAXB) % 2) == 1));
      chk("burst_no_bubble", 32'(sa_m0_gnt | sa_m1_gnt), 32'h1);
    end
    idle(1);

    // m0 alone once, then m1 alone: immediate switch, then m1 holds 3 more under contention
    drive(1, 0, 32'h24, 32'h0, 0, 0, 32'h0, 32'h0);
    tick();
    chk("solo_m0_gnt", 32'(sa_m0_gnt), 32'h1);
    drive(0, 0, 32'h0, 32'h0, 1, 1, 32'h34, 32'h5555AAAA);
    tick();
    chk("switch_m1_gnt", 32'(sa_m1_gnt), 32'h1);
    drive(1, 0, 32'h24, 32'h0, 1, 1, 32'h34, 32'h5555AAAA);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_m1_gnt", 32'(sa_m1_gnt), 32'h1);
    end
    tick();
    chk("hold_end_m0_gnt", 32'(sa_m0_gnt), 32'h1);
    idle(4);

    // alternating reads, latency-3 instance returns in issue order
    drive(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 32'h0, 1, 0, 32'h4, 32'h0);
    tick();
    drive(1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0);
    tick();
    idle(1);
    chk("alt_0_m0_rvalid", 32'({sb_m0_rv, sb_m1_rv}), 32'h2);
    chk("alt_0_rdata", sb_m0_rd, 32'hC0DE0000);
    idle(1);
    chk("alt_1_m1_rvalid", 32'({sb_m0_rv, sb_m1_rv}), 32'h1);
    chk("alt_1_rdata", sb_m1_rd, 32'hC0DE0001);
    idle(1);
    chk("alt_2_m0_rvalid", 32'({sb_m0_rv, sb_m1_rv}), 32'h2);
    chk("alt_2_rdata", sb_m0_rd, 32'hC0DE0002);
    idle(3);

    // read accepted, reset one cycle later: response is dropped
    drive(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("drop_busy", 32'({sa_busy, sb_busy}), 32'h0);
      chk("drop_rvalid", 32'({sa_m0_rv, sa_m1_rv, sb_m0_rv, sb_m1_rv}), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
